// File: rtl/axi4_duth_noc_ni_pkg.sv
// Shared types for the slave-NI request packetizer: flit types, header control fields, FSM states.
// flit_w() sizes a flit to hold either a request header or one write beat with its strobes.
package axi4_duth_noc_ni_pkg;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_HEAD      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_t;

  // Fixed-width AXI control fields that trail id/addr in a head flit.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } req_hdr_t;

  localparam int HDR_CTL_W = $bits(req_hdr_t);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_W_DATA = 1'b1
  } pk_state_t;

  function automatic int flit_w(input int id_w, input int addr_w, input int data_w);
    int hdr_w;
    int beat_w;
    hdr_w  = 1 + id_w + addr_w + HDR_CTL_W;
    beat_w = data_w + data_w / 8;
    return 2 + ((hdr_w > beat_w) ? hdr_w : beat_w);
  endfunction

endpackage

// File: rtl/ni_beat_counter.sv
// Write-beat counter: load clears the count and captures the burst length, inc advances per beat.
// is_last flags the beat whose index equals the captured length (the TAIL beat).
module ni_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       inc,
  input  logic [7:0] len,
  output logic [7:0] count,
  output logic       is_last
);

  logic [7:0] len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
      len_q <= 8'd0;
    end else if (load) begin
      count <= 8'd0;
      len_q <= len;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign is_last = (count == len_q);

endmodule

// File: rtl/axi_req_packetizer.sv
// Slave-NI packetizer: serializes the granted AW+W burst or AR request into NoC flits, zero latency.
// Readies mirror flit_ready for the active source only; update_pri pulses on the final flit handshake.
module axi_req_packetizer
  import axi4_duth_noc_ni_pkg::*;
#(
  parameter int  ID_W   = 4,
  parameter int  ADDR_W = 32,
  parameter int  DATA_W = 64,
  localparam int FLIT_W = flit_w(ID_W, ADDR_W, DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [7:0]          aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [7:0]          ar_len,
  input  logic [2:0]          ar_size,
  input  logic [1:0]          ar_burst,
  input  logic [1:0]          active_channel,
  input  logic                anyactive,
  output logic [1:0]          update_pri,
  output logic                flit_valid,
  input  logic                flit_ready,
  output logic [FLIT_W-1:0]   flit_data,
  output logic                len_err
);

  localparam int HDR_W = 1 + ID_W + ADDR_W + HDR_CTL_W;
  localparam int PAY_W = FLIT_W - 2;

  pk_state_t  state_q, state_d;
  flit_type_t ftype;
  logic [PAY_W-1:0] payload;
  logic [PAY_W-1:0] aw_pay, ar_pay, w_pay;
  logic [HDR_W-1:0] aw_hdr, ar_hdr;
  req_hdr_t   aw_ctl, ar_ctl;
  logic       cnt_load, cnt_inc, is_last;
  logic [7:0] beat_cnt;

  assign aw_ctl = '{len: aw_len, size: aw_size, burst: aw_burst};
  assign ar_ctl = '{len: ar_len, size: ar_size, burst: ar_burst};
  assign aw_hdr = {1'b0, aw_id, aw_addr, aw_ctl};
  assign ar_hdr = {1'b1, ar_id, ar_addr, ar_ctl};
  assign aw_pay = PAY_W'(aw_hdr);
  assign ar_pay = PAY_W'(ar_hdr);
  assign w_pay  = PAY_W'({w_strb, w_data});

  ni_beat_counter u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .len     (aw_len),
    .count   (beat_cnt),
    .is_last (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Everything is gated by rst so the NoC side sees silence during reset, even mid-packet.
  always_comb begin
    state_d    = state_q;
    aw_ready   = 1'b0;
    ar_ready   = 1'b0;
    w_ready    = 1'b0;
    flit_valid = 1'b0;
    update_pri = 2'b00;
    ftype      = FT_BODY;
    payload    = '0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (anyactive && active_channel == 2'b01) begin
            flit_valid = aw_valid;
            ftype      = FT_HEAD;
            payload    = aw_pay;
            aw_ready   = flit_ready;
            if (aw_valid && flit_ready) begin
              cnt_load = 1'b1;
              state_d  = ST_W_DATA;
            end
          end else if (anyactive && active_channel == 2'b10) begin
            flit_valid = ar_valid;
            ftype      = FT_HEAD_TAIL;
            payload    = ar_pay;
            ar_ready   = flit_ready;
            if (ar_valid && flit_ready) update_pri = 2'b10;
          end
        end
        ST_W_DATA: begin
          // The beat counter, not w_last, decides where the packet ends.
          flit_valid = w_valid;
          ftype      = is_last ? FT_TAIL : FT_BODY;
          payload    = w_pay;
          w_ready    = flit_ready;
          if (w_valid && flit_ready) begin
            cnt_inc = 1'b1;
            if (is_last) begin
              update_pri = 2'b01;
              state_d    = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign flit_data = {ftype, payload};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          len_err <= 1'b0;
    else if (w_valid && w_ready && (w_last != is_last)) len_err <= 1'b1;
  end

endmodule
